// File: rtl/buffer_double_ctrl_pkg.sv
// Shared types for the double-buffer accumulation sequencer.
// Optional stall counter: BUFFER_DOUBLE_CTRL_STALL_CNT_EN.
package buffer_double_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ACC,
    WAIT
  } bdc_state_t;

  localparam int CLEAR_LEN = 1;

endpackage

// File: rtl/buffer_double_ctrl_if.sv
// Upstream valid/ready and downstream valid/ack bundle.
// master = controller side, slave = environment side.
interface buffer_double_ctrl_if;

  logic iInValid;
  logic oInReady;
  logic oOutValid;
  logic oOutSel;
  logic iOutAck;

  modport master (
    input  iInValid,
    input  iOutAck,
    output oInReady,
    output oOutValid,
    output oOutSel
  );

  modport slave (
    output iInValid,
    output iOutAck,
    input  oInReady,
    input  oOutValid,
    input  oOutSel
  );

endinterface

// File: rtl/buffer_double_ctrl_win_counter.sv
// Beat counter for one accumulation window.
// Wraps after the last beat; clr has priority over inc.
module win_counter #(
  parameter int WIN_LEN = 256,
  parameter int CWID    = $clog2(WIN_LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [CWID-1:0] cnt,
  output logic            last
);

  localparam logic [CWID-1:0] LAST_VAL =
    CWID'(WIN_LEN - 1);

  assign last = (cnt == LAST_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CWID'(1);
    end
  end

endmodule

// File: rtl/buffer_double_ctrl.sv
// Ping-pong bank sequencer for the unary accumulator array.
// `define BUFFER_DOUBLE_CTRL_STALL_CNT_EN adds oStallCnt.
module buffer_double_ctrl
  import buffer_double_ctrl_pkg::*;
#(
  parameter int WIN_LEN = 256,
  parameter int CWID    = $clog2(WIN_LEN),
  parameter int WCWID   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic             iStop,
  buffer_double_ctrl_if.master bus,
  output logic             oAccSel,
  output logic             oClear,
  output logic             oHold,
`ifdef BUFFER_DOUBLE_CTRL_STALL_CNT_EN
  output logic [31:0]      oStallCnt,
`endif
  output logic [WCWID-1:0] oWinCnt
);

  bdc_state_t state;
  bdc_state_t nstate;

  logic            in_ready;
  logic            out_valid;
  logic            out_sel;
  logic            stop_pend;
  logic            beat;
  logic            publish;
  logic            last;
  logic            bank_free;
  logic            stop_now;
  logic [CWID-1:0] unused_cnt;

  assign bus.oInReady  = in_ready;
  assign bus.oOutValid = out_valid;
  assign bus.oOutSel   = out_sel;

  assign bank_free = ~out_valid | bus.iOutAck;
  assign stop_now  = stop_pend | iStop;

  win_counter #(
    .WIN_LEN (WIN_LEN),
    .CWID    (CWID)
  ) u_win (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == CLEAR),
    .inc  (beat),
    .cnt  (unused_cnt),
    .last (last)
  );

  always_comb begin
    nstate   = state;
    in_ready = 1'b0;
    oClear   = 1'b0;
    oHold    = 1'b1;
    beat     = 1'b0;
    publish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart) nstate = CLEAR;
      end
      CLEAR: begin
        oClear = 1'b1;
        nstate = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        oHold    = ~bus.iInValid;
        beat     = bus.iInValid;
        if (beat && last) begin
          if (bank_free) begin
            publish = 1'b1;
            nstate  = stop_now ? IDLE : CLEAR;
          end else begin
            nstate = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.iOutAck) begin
          publish = 1'b1;
          nstate  = stop_now ? IDLE : CLEAR;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      oAccSel   <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      oWinCnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= nstate;
      // A publish with a same-cycle ack keeps valid high.
      if (publish) begin
        out_valid <= 1'b1;
        out_sel   <= oAccSel;
        oAccSel   <= ~oAccSel;
        oWinCnt   <= oWinCnt + WCWID'(1);
      end else if (bus.iOutAck && out_valid) begin
        out_valid <= 1'b0;
      end
      if (state != IDLE && nstate == IDLE) begin
        stop_pend <= 1'b0;
      end else if (state != IDLE && iStop) begin
        stop_pend <= 1'b1;
      end
    end
  end

`ifdef BUFFER_DOUBLE_CTRL_STALL_CNT_EN
  logic stall;

  assign stall = (state == WAIT) ||
                 (state == ACC && !bus.iInValid);

  always_ff @(posedge clk) begin
    if (rst) begin
      oStallCnt <= '0;
    end else if (state == IDLE && iStart) begin
      oStallCnt <= '0;
    end else if (stall && oStallCnt != '1) begin
      oStallCnt <= oStallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_double_ctrl.sv
// Scoreboard bench for buffer_double_ctrl with WIN_LEN=4.
// Publishes are predicted per window and popped on oWinCnt steps.
module tb_buffer_double_ctrl;

  logic        clk;
  logic        rst;
  logic        iStart;
  logic        iStop;
  logic        oAccSel;
  logic        oClear;
  logic        oHold;
  logic [15:0] oWinCnt;
`ifdef BUFFER_DOUBLE_CTRL_STALL_CNT_EN
  logic [31:0] oStallCnt;
`endif

  buffer_double_ctrl_if bus ();

  buffer_double_ctrl #(
    .WIN_LEN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iStart    (iStart),
    .iStop     (iStop),
    .bus       (bus),
    .oAccSel   (oAccSel),
    .oClear    (oClear),
    .oHold     (oHold),
`ifdef BUFFER_DOUBLE_CTRL_STALL_CNT_EN
    .oStallCnt (oStallCnt),
`endif
    .oWinCnt   (oWinCnt)
  );

  typedef struct {
    logic        sel;
    logic [15:0] cnt;
  } pub_t;

  pub_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        exp_bank = 1'b0;
  logic [15:0] exp_win  = '0;
  logic [15:0] prev_wc  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push_win();
    pub_t p;
    p.sel = exp_bank;
    p.cnt = exp_win + 16'd1;
    sb_q.push_back(p);
    exp_bank = ~exp_bank;
    exp_win  = exp_win + 16'd1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    iStart       = 1'b0;
    iStop        = 1'b0;
    bus.iInValid = 1'b0;
    bus.iOutAck  = 1'b0;
    nxt();
    rst      = 1'b0;
    exp_bank = 1'b0;
    exp_win  = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_accsel"}, {31'd0, oAccSel}, 0);
    chk({tag, "_clear"}, {31'd0, oClear}, 0);
    chk({tag, "_hold"}, {31'd0, oHold}, 1);
    chk({tag, "_ready"}, {31'd0, bus.oInReady}, 0);
    chk({tag, "_oval"}, {31'd0, bus.oOutValid}, 0);
    chk({tag, "_osel"}, {31'd0, bus.oOutSel}, 0);
    chk({tag, "_wcnt"}, {16'd0, oWinCnt}, 0);
  endtask

  task automatic beats4(input logic sel);
    for (int b = 1; b <= 4; b++) begin
      chk("acc_rdy", {31'd0, bus.oInReady}, 1);
      chk("acc_hold", {31'd0, oHold}, 0);
      chk("acc_sel", {31'd0, oAccSel}, {31'd0, sel});
      if (b == 4) push_win();
      nxt();
    end
  endtask

  always @(negedge clk) begin
    if (oWinCnt != prev_wc && oWinCnt != 16'd0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {16'd0, oWinCnt}, 0);
      end else begin
        pub_t e;
        e = sb_q.pop_front();
        chk("pub_sel", {31'd0, bus.oOutSel}, {31'd0, e.sel});
        chk("pub_cnt", {16'd0, oWinCnt}, {16'd0, e.cnt});
        chk("pub_valid", {31'd0, bus.oOutValid}, 1);
      end
    end
    prev_wc = oWinCnt;
  end

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r            = 4'($urandom);
      iStart       = r[0];
      iStop        = r[1];
      bus.iInValid = r[2];
      bus.iOutAck  = r[3];
      nxt();
      chk("rst_hold", {31'd0, oHold}, 1);
      chk("rst_ready", {31'd0, bus.oInReady}, 0);
    end
    chk_reset_vals("rst");
    do_reset();

    // Free-run with ack tied high
    bus.iInValid = 1'b1;
    bus.iOutAck  = 1'b1;
    iStart       = 1'b1;
    nxt();
    iStart = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("fr_clear", {31'd0, oClear}, 1);
      chk("fr_clr_hold", {31'd0, oHold}, 1);
      chk("fr_clr_rdy", {31'd0, bus.oInReady}, 0);
      nxt();
      chk("fr_oval_low", {31'd0, bus.oOutValid}, 0);
      beats4(w[0]);
      chk("fr_oval", {31'd0, bus.oOutValid}, 1);
      chk("fr_osel", {31'd0, bus.oOutSel}, {31'd0, w[0]});
      chk("fr_accsel", {31'd0, oAccSel}, {31'd0, ~w[0]});
    end
    chk("fr_wcnt", {16'd0, oWinCnt}, 3);

    // Backpressure into WAIT
    do_reset();
    bus.iInValid = 1'b1;
    iStart       = 1'b1;
    nxt();
    iStart = 1'b0;
    nxt();
    beats4(1'b0);
    chk("bp_oval0", {31'd0, bus.oOutValid}, 1);
    chk("bp_accsel0", {31'd0, oAccSel}, 1);
    nxt();
    beats4(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_w_rdy", {31'd0, bus.oInReady}, 0);
      chk("bp_w_hold", {31'd0, oHold}, 1);
      chk("bp_w_accsel", {31'd0, oAccSel}, 1);
      chk("bp_w_oval", {31'd0, bus.oOutValid}, 1);
      chk("bp_w_osel", {31'd0, bus.oOutSel}, 0);
      if (i == 2) bus.iOutAck = 1'b1;
      nxt();
    end
    bus.iOutAck = 1'b0;
    chk("bp_oval1", {31'd0, bus.oOutValid}, 1);
    chk("bp_osel1", {31'd0, bus.oOutSel}, 1);
    chk("bp_accsel1", {31'd0, oAccSel}, 0);
    chk("bp_clear", {31'd0, oClear}, 1);
    chk("bp_wcnt", {16'd0, oWinCnt}, 2);

    // Gapped input
    do_reset();
    bus.iOutAck = 1'b1;
    iStart      = 1'b1;
    nxt();
    iStart = 1'b0;
    nxt();
    for (int k = 0; k < 8; k++) begin
      bus.iInValid = k[0];
      #1;
      chk("gap_hold", {31'd0, oHold}, {31'd0, ~bus.iInValid});
      chk("gap_rdy", {31'd0, bus.oInReady}, 1);
      if (k == 7) push_win();
      nxt();
    end
    chk("gap_clear", {31'd0, oClear}, 1);
    chk("gap_oval", {31'd0, bus.oOutValid}, 1);
    chk("gap_osel", {31'd0, bus.oOutSel}, 0);

    // Stop after the current window
    do_reset();
    bus.iOutAck  = 1'b1;
    bus.iInValid = 1'b1;
    iStart       = 1'b1;
    nxt();
    iStart = 1'b0;
    nxt();
    for (int b = 1; b <= 4; b++) begin
      iStop = (b == 2);
      chk("st_accsel", {31'd0, oAccSel}, 0);
      if (b == 4) push_win();
      nxt();
    end
    iStop = 1'b0;
    chk("st_hold", {31'd0, oHold}, 1);
    chk("st_rdy", {31'd0, bus.oInReady}, 0);
    chk("st_clear", {31'd0, oClear}, 0);
    chk("st_oval", {31'd0, bus.oOutValid}, 1);
    chk("st_osel", {31'd0, bus.oOutSel}, 0);
    chk("st_accsel1", {31'd0, oAccSel}, 1);
    nxt();
    chk("st_idle_rdy", {31'd0, bus.oInReady}, 0);
    chk("st_idle_oval", {31'd0, bus.oOutValid}, 0);
    iStart = 1'b1;
    nxt();
    iStart = 1'b0;
    chk("st_re_clear", {31'd0, oClear}, 1);
    nxt();
    beats4(1'b1);
    chk("st_re_clear2", {31'd0, oClear}, 1);
    chk("st_re_osel", {31'd0, bus.oOutSel}, 1);
    chk("st_re_wcnt", {16'd0, oWinCnt}, 2);

    // Reset in the middle of a window
    bus.iOutAck = 1'b0;
    nxt();
    nxt();
    nxt();
    chk("mr_oval", {31'd0, bus.oOutValid}, 1);
    rst = 1'b1;
    nxt();
    chk_reset_vals("mr");
    rst      = 1'b0;
    exp_bank = 1'b0;
    exp_win  = '0;
    bus.iOutAck = 1'b1;
    iStart      = 1'b1;
    nxt();
    iStart = 1'b0;
    chk("mr_clear", {31'd0, oClear}, 1);
    nxt();
    beats4(1'b0);
    chk("mr_osel", {31'd0, bus.oOutSel}, 0);
    chk("mr_wcnt", {16'd0, oWinCnt}, 1);
    chk("mr_accsel", {31'd0, oAccSel}, 1);

    bus.iInValid = 1'b0;
    nxt();
    nxt();
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
